// File: rtl/ic1406_seq_pkg.sv
// Shared types and defaults for the ic1406 command sequencer.
// Optional q capture: define IC1406_SEQ_QCAPTURE_EN.
package ic1406_seq_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam logic [2:0] IDLE_A_DEF = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SETTLE,
    REPORT
  } state_t;

  typedef struct packed {
    logic [2:0]           a;
    logic [CNT_W_DEF-1:0] len;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/ic1406_cmd_fifo.sv
// Registered command FIFO, no bypass; head entry visible on dout.
// DEPTH must be a power of two so the pointers wrap for free.
module ic1406_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ic1406_seq_ctrl.sv
// Command sequencer driving one ic1406: queue, run, settle, report.
// Define IC1406_SEQ_QCAPTURE_EN to return the settled {Q1,Q0} in rsp_q.
module ic1406_seq_ctrl
  import ic1406_seq_pkg::*;
#(
  parameter int         DEPTH  = DEPTH_DEF,
  parameter int         CNT_W  = CNT_W_DEF,
  parameter logic [2:0] IDLE_A = IDLE_A_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_a,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [2:0]     a_out,
  input  logic           z_in,
  input  logic [1:0]     q_in,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [CNT_W:0] rsp_zcnt,
  output logic [1:0]     rsp_q,
  output logic           busy
);

  localparam int FW = 3 + CNT_W;

  state_t           state;
  logic [2:0]       cur_a;
  logic [CNT_W-1:0] cur_len;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W:0]   zcnt;
  logic [FW-1:0]    head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign push = cmd_valid && !full;
  assign pop  = (state == IDLE) && !empty;

  ic1406_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({cmd_a, cmd_len}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd_ready = !full;
  assign a_out     = (state == RUN) ? cur_a : IDLE_A;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == REPORT);
  assign rsp_zcnt  = zcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_a   <= IDLE_A;
      cur_len <= '0;
      run_cnt <= '0;
      zcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            cur_a   <= head[FW-1:CNT_W];
            cur_len <= head[CNT_W-1:0];
            run_cnt <= '0;
            zcnt    <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          // first RUN edge precedes any applied vector edge
          if (run_cnt != '0) zcnt <= zcnt + {{CNT_W{1'b0}}, z_in};
          if (run_cnt == cur_len) state <= SETTLE;
          else run_cnt <= run_cnt + CNT_W'(1);
        end
        SETTLE: begin
          zcnt  <= zcnt + {{CNT_W{1'b0}}, z_in};
          state <= REPORT;
        end
        REPORT: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IC1406_SEQ_QCAPTURE_EN
  logic [1:0] qcap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qcap <= 2'b00;
    else if (state == SETTLE) qcap <= q_in;
  end

  assign rsp_q = qcap;
`else
  logic unused_q;

  assign unused_q = ^q_in;
  assign rsp_q    = 2'b00;
`endif

endmodule

// File: tb/tb_ic1406_seq_ctrl.sv
// Directed bench for ic1406_seq_ctrl.
// Build with IC1406_SEQ_QCAPTURE_EN to check the q capture path.
module tb_ic1406_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_a;
  logic [3:0] cmd_len;
  logic [2:0] a_out;
  logic       z_in;
  logic [1:0] q_in;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_zcnt;
  logic [1:0] rsp_q;
  logic       busy;

  int tests = 0;
  int fails = 0;

`ifdef IC1406_SEQ_QCAPTURE_EN
  localparam logic [1:0] QEXP = 2'b10;
`else
  localparam logic [1:0] QEXP = 2'b00;
`endif

  always #5 clk = ~clk;

  ic1406_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_len   (cmd_len),
    .a_out     (a_out),
    .z_in      (z_in),
    .q_in      (q_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_zcnt  (rsp_zcnt),
    .rsp_q     (rsp_q),
    .busy      (busy)
  );

  // offer one command for one cycle; returns at the next negedge
  task automatic push(input logic [2:0] a, input logic [3:0] len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_a = 3'b000;
    cmd_len = 4'd0;
    z_in = 1'b0;
    q_in = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (a_out !== 3'b000 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1
        || busy !== 1'b0 || rsp_zcnt !== 5'd0 || rsp_q !== 2'b00) begin
      fails++;
      $display("FAIL reset: a_out=%b rsp_valid=%b cmd_ready=%b busy=%b zcnt=%0d q=%b, want 000 0 1 0 0 00",
               a_out, rsp_valid, cmd_ready, busy, rsp_zcnt, rsp_q);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    z_in = 1'b1;
    q_in = 2'b10;
    push(3'b101, 4'd3);
    tests++;
    if (a_out !== 3'b000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_prepop: a_out=%b busy=%b, want 000 0", a_out, busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (a_out !== 3'b101) begin
        fails++;
        $display("FAIL single_run%0d: a_out=%b, want 101", i, a_out);
      end
    end
    @(negedge clk);
    tests++;
    if (a_out !== 3'b000 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_settle: a_out=%b rsp_valid=%b busy=%b, want 000 0 1",
               a_out, rsp_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_zcnt !== 5'd4 || rsp_q !== QEXP) begin
        fails++;
        $display("FAIL single_rsp%0d: valid=%b zcnt=%0d q=%b, want 1 4 %b",
                 i, rsp_valid, rsp_zcnt, rsp_q, QEXP);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_accept: valid=%b busy=%b, want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_zpattern;
    z_in = 1'b0;
    push(3'b011, 4'd2);
    repeat (4) @(negedge clk);
    z_in = 1'b1;
    @(negedge clk);
    z_in = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_zcnt !== 5'd1) begin
      fails++;
      $display("FAIL zpattern: valid=%b zcnt=%0d, want 1 1", rsp_valid, rsp_zcnt);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_full_stall;
    int got;
    z_in = 1'b1;
    rsp_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (cmd_ready !== 1'b1) begin
        fails++;
        $display("FAIL full_ready%0d: cmd_ready=%b, want 1", k, cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_a = 3'(k + 1);
      cmd_len = 4'(k);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (4) begin
      tests++;
      if (cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL full_stall: cmd_ready=%b, want 0", cmd_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && got < 5; c++) begin
      if (rsp_valid === 1'b1) begin
        tests++;
        if (rsp_zcnt !== 5'(got + 1)) begin
          fails++;
          $display("FAIL full_order%0d: zcnt=%0d, want %0d", got, rsp_zcnt, got + 1);
        end
        got++;
      end
      @(negedge clk);
    end
    tests++;
    if (got != 5) begin
      fails++;
      $display("FAIL full_count: responses=%0d, want 5", got);
    end
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [2:0] ea [6];
    logic       ev [6];
    ea = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
    ev = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rsp_ready = 1'b1;
    push(3'b001, 4'd0);
    cmd_valid = 1'b1;
    cmd_a = 3'b010;
    cmd_len = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (a_out !== ea[i] || rsp_valid !== ev[i]) begin
        fails++;
        $display("FAIL b2b_cyc%0d: a_out=%b valid=%b, want %b %b",
                 i, a_out, rsp_valid, ea[i], ev[i]);
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_midrun_reset;
    int seen;
    push(3'b110, 4'd7);
    push(3'b001, 4'd1);
    push(3'b010, 4'd1);
    @(negedge clk);
    tests++;
    if (a_out !== 3'b110) begin
      fails++;
      $display("FAIL midrun_pre: a_out=%b, want 110", a_out);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (a_out !== 3'b000 || busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: a_out=%b busy=%b ready=%b valid=%b, want 000 0 1 0",
               a_out, busy, cmd_ready, rsp_valid);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL midrun_empty: active cycles=%0d, want 0", seen);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_qcapture_maxlen;
    z_in = 1'b1;
    q_in = 2'b01;
    push(3'b111, 4'd15);
    repeat (16) @(negedge clk);
    tests++;
    if (a_out !== 3'b111) begin
      fails++;
      $display("FAIL maxlen_last: a_out=%b, want 111", a_out);
    end
    @(negedge clk);
    q_in = 2'b10;
    tests++;
    if (a_out !== 3'b000 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL maxlen_settle: a_out=%b valid=%b, want 000 0", a_out, rsp_valid);
    end
    @(negedge clk);
    q_in = 2'b11;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_zcnt !== 5'd16 || rsp_q !== QEXP) begin
      fails++;
      $display("FAIL maxlen_rsp: valid=%b zcnt=%0d q=%b, want 1 16 %b",
               rsp_valid, rsp_zcnt, rsp_q, QEXP);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zpattern();
    test_full_stall();
    test_back_to_back();
    test_midrun_reset();
    test_qcapture_maxlen();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
